regfile_wb_scheduler: RTL and testbench
=======================================

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, write-queue entries (power of two, >=4).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port wb0_valid  input  1  lane-0 (older) writeback request.
REQ-005 SHALL have port wb0_reg  input  5  lane-0 destination register.
REQ-006 SHALL have port wb0_data  input  32  lane-0 write data.
REQ-007 SHALL have port wb1_valid  input  1  lane-1 (younger) writeback request.
REQ-008 SHALL have port wb1_reg  input  5  lane-1 destination register.
REQ-009 SHALL have port wb1_data  input  32  lane-1 write data.
REQ-010 SHALL have port wb_ready  output  1  both lanes accepted at the next edge when high.
REQ-011 SHALL have port ctrl_writeEnable  output  1  regfile single write-port enable.
REQ-012 SHALL have port ctrl_writeReg  output  5  regfile write address (feeds 5-to-32 write decoder).
REQ-013 SHALL have port data_writeReg  output  32  regfile write data.
REQ-014 SHALL have port probe_reg  input  5  source register queried by hazard logic.
REQ-015 SHALL have port probe_hit  output  1  probe_reg matches a queued (unwritten) entry.
REQ-016 SHALL have port pend_count  output  3  number of queued entries.

Function
REQ-017 SHALL hold a circular FIFO of {reg[4:0], data[31:0]} entries with head/tail pointers and a count register.
REQ-018 SHALL drive wb_ready = 1 iff registered count <= QDEPTH-2; purely from registers, no input-to-ready path.
REQ-019 SHALL accept lane requests at an edge only when wb_ready=1; valid lanes while wb_ready=0 are ignored and must be held by the requester.
REQ-020 SHALL discard (not enqueue) an accepted request whose reg = 0; register 0 is never written.
REQ-021 SHALL, when both lanes valid with equal nonzero reg, enqueue only lane 1 (younger wins) and drop lane 0.
REQ-022 SHALL otherwise enqueue lane 0 then lane 1 in that order (0, 1 or 2 entries per edge).
REQ-023 SHALL drive ctrl_writeEnable = (count != 0), ctrl_writeReg/data_writeReg = head entry; zeros when empty.
REQ-024 SHALL dequeue the head at every edge where count != 0 (regfile writes on that edge); one write per cycle max.
REQ-025 SHALL update count = count + enq - deq with simultaneous enqueue and dequeue in the same edge; pointers wrap modulo QDEPTH.
REQ-026 SHALL give latency of exactly one edge from acceptance to regfile write when the queue was empty (lane 1 of a pair: two edges).
REQ-027 SHALL drive probe_hit = 1 iff probe_reg != 0 and any occupied entry has reg = probe_reg; entries enqueued at the current edge excluded until registered.
REQ-028 SHALL never overflow: count max is QDEPTH-1 under REQ-018; count never underflows.
REQ-029 SHALL drive pend_count = count.

Reset
REQ-030 SHALL, on reset=0 (asynchronous, any time including mid-drain), clear count, head, tail to 0, forcing ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, probe_hit=0, wb_ready=1; queued entries are lost.
REQ-031 SHALL resume normal acceptance at the first rising edge after reset returns to 1; entry storage need not be reset.

Verification
REQ-032 Single write: empty, wb0_valid=1 reg=5 data=0xDEADBEEF, wb1_valid=0 -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data=0xDEADBEEF; following cycle enable=0, pend_count=0.
REQ-033 Pair: wb0 reg=3 data=0x11, wb1 reg=7 data=0x22 -> writes r3/0x11 cycle 1, r7/0x22 cycle 2, in order; pend_count 2 then 1 then 0.
REQ-034 Collision/r0: wb0 reg=9 data=0xA, wb1 reg=9 data=0xB -> single write r9=0xB; wb0 reg=0, wb1 reg=0 -> no write, pend_count stays 0.
REQ-035 Backpressure: pairs of nonzero distinct regs every cycle -> pend_count reaches 3, wb_ready=0 while count=3, never exceeds 3, every accepted write appears exactly once in order.
REQ-036 Hazard probe: queue holds r12 -> probe_reg=12 gives probe_hit=1, probe_reg=13 gives 0, probe_reg=0 gives 0; after r12 drains, probe_hit=0.
REQ-037 Reset mid-drain: pend_count=3, assert reset=0 between edges -> ctrl_writeEnable=0, pend_count=0 immediately (asynchronous), no further writes after release.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Two-lane writeback scheduler: merges lane 0/1 results into a small FIFO that
// drains one entry per cycle into the register file's single write port.
module regfile_wb_scheduler #(
    parameter int QDEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb0_valid,
    input  logic [4:0]  wb0_reg,
    input  logic [31:0] wb0_data,
    input  logic        wb1_valid,
    input  logic [4:0]  wb1_reg,
    input  logic [31:0] wb1_data,
    output logic        wb_ready,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    input  logic [4:0]  probe_reg,
    output logic        probe_hit,
    output logic [2:0]  pend_count
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    mem_reg  [QDEPTH];
    logic [31:0]   mem_data [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          take0;
    logic          take1;
    logic          deq;

    // Handshake: a lane transfers at a rising edge when its valid and wb_ready
    // are both high; wb_ready comes only from count, so a requester seeing it low
    // holds its request unchanged until an edge where wb_ready is high.
    assign wb_ready = (count <= CW'(QDEPTH - 2));

    // Lane 0 loses a same-register collision because lane 1 holds the newer value.
    always_comb begin
        take0 = 1'b0;
        take1 = 1'b0;
        take0 = wb_ready && wb0_valid && (wb0_reg != 5'd0) &&
                !(wb1_valid && (wb1_reg == wb0_reg));
        take1 = wb_ready && wb1_valid && (wb1_reg != 5'd0);
    end

    assign deq = (count != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= count + CW'(take0) + CW'(take1) - CW'(deq);
            head  <= head + PW'(deq);
            tail  <= tail + PW'(take0) + PW'(take1);
        end
    end

    // Entry storage is never read unless occupied, so it carries no reset.
    always_ff @(posedge clock) begin
        if (take0) begin
            mem_reg[tail]  <= wb0_reg;
            mem_data[tail] <= wb0_data;
        end
        if (take1) begin
            mem_reg[take0 ? tail + PW'(1) : tail]  <= wb1_reg;
            mem_data[take0 ? tail + PW'(1) : tail] <= wb1_data;
        end
    end

    assign ctrl_writeEnable = deq;
    assign ctrl_writeReg    = deq ? mem_reg[head]  : 5'd0;
    assign data_writeReg    = deq ? mem_data[head] : 32'd0;
    assign pend_count       = 3'(count);

    // A slot is occupied when its distance from head is below count.
    always_comb begin
        probe_hit = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if ((CW'(PW'(PW'(i) - head)) < count) && (mem_reg[i] == probe_reg)) begin
                probe_hit = 1'b1;
            end
        end
        if (probe_reg == 5'd0) begin
            probe_hit = 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed and random writeback traffic checked
// against a queue model of pending register writes.
module tb_regfile_wb_scheduler;
    localparam int QDEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wb0_valid = 1'b0;
    logic [4:0]  wb0_reg = '0;
    logic [31:0] wb0_data = '0;
    logic        wb1_valid = 1'b0;
    logic [4:0]  wb1_reg = '0;
    logic [31:0] wb1_data = '0;
    logic        wb_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  probe_reg = '0;
    logic        probe_hit;
    logic [2:0]  pend_count;

    regfile_wb_scheduler #(.QDEPTH(QDEPTH)) dut (
        .clock(clock), .reset(reset),
        .wb0_valid(wb0_valid), .wb0_reg(wb0_reg), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_reg(wb1_reg), .wb1_data(wb1_data),
        .wb_ready(wb_ready), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .probe_reg(probe_reg), .probe_hit(probe_hit), .pend_count(pend_count)
    );

    always #5 clock = ~clock;

    // exp_q: writes still owed to the register file, oldest first.
    logic [36:0] exp_q[$];
    logic [36:0] pend_q[$];
    bit          last_acc = 1'b1;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    logic        h_v0, h_v1;
    logic [4:0]  h_r0, h_r1, h_pr;
    logic [31:0] h_d0, h_d1;

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic model_hit(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (exp_q[i]) if (exp_q[i][36:32] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: away from the active edge, compare visible state to the model.
    always @(negedge clock) begin
        if (mon_en && reset) begin
            check("pend_count", 37'(pend_count), 37'(exp_q.size()));
            check("wb_ready", 37'(wb_ready), 37'(exp_q.size() <= QDEPTH - 2));
            check("write_enable", 37'(ctrl_writeEnable), 37'(exp_q.size() != 0));
            check("probe_hit", 37'(probe_hit), 37'(model_hit(probe_reg)));
            if (exp_q.size() != 0) check("write_entry", {ctrl_writeReg, data_writeReg}, exp_q.pop_front());
            else check("idle_bus", {ctrl_writeReg, data_writeReg}, 37'd0);
        end
    end

    // Driver: after each edge, commit what the previous edge accepted, then
    // present new requests and predict whether the coming edge accepts them.
    task automatic step(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] pr);
        @(posedge clock);
        #1;
        while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
        wb0_valid = v0; wb0_reg = r0; wb0_data = d0;
        wb1_valid = v1; wb1_reg = r1; wb1_data = d1;
        probe_reg = pr;
        last_acc = (exp_q.size() <= QDEPTH - 2);
        if (last_acc && reset) begin
            if (v0 && r0 != 5'd0 && !(v1 && r1 == r0)) pend_q.push_back({r0, d0});
            if (v1 && r1 != 5'd0) pend_q.push_back({r1, d1});
        end
    endtask

    task automatic idle(input int n, input logic [4:0] pr);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, pr);
    endtask

    // Random request; a refused request is held unchanged until accepted.
    task automatic rand_cycle(input bit heavy);
        if (last_acc) begin
            h_v0 = heavy ? 1'b1 : 1'($urandom_range(0, 1));
            h_v1 = heavy ? 1'b1 : 1'($urandom_range(0, 1));
            h_r0 = 5'($urandom_range(0, 9));
            h_r1 = 5'($urandom_range(0, 9));
            h_d0 = $urandom;
            h_d1 = $urandom;
        end
        h_pr = 5'($urandom_range(0, 9));
        step(h_v0, h_r0, h_d0, h_v1, h_r1, h_d1, h_pr);
    endtask

    initial begin
        #12;
        check("rst_pend_count", 37'(pend_count), 37'd0);
        check("rst_write_enable", 37'(ctrl_writeEnable), 37'd0);
        check("rst_wb_ready", 37'(wb_ready), 37'd1);
        check("rst_bus", {ctrl_writeReg, data_writeReg}, 37'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        mon_en = 1'b1;

        // Single write, then a pair, then a collision and an r0 pair.
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5);
        idle(2, 5'd5);
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22, 5'd7);
        idle(3, 5'd3);
        step(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB, 5'd9);
        idle(2, 5'd9);
        step(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, 5'd0);
        idle(2, 5'd0);

        // Hazard probe against a queued r12 with hit, miss and r0 queries.
        step(1'b1, 5'd12, 32'hC0C0, 1'b0, 5'd0, 32'd0, 5'd12);
        idle(1, 5'd12);
        step(1'b1, 5'd12, 32'hC1C1, 1'b0, 5'd0, 32'd0, 5'd13);
        idle(1, 5'd12);
        step(1'b1, 5'd12, 32'hC2C2, 1'b0, 5'd0, 32'd0, 5'd0);
        idle(2, 5'd12);

        // Back-to-back distinct pairs saturate the queue; refused pairs are held.
        for (int i = 0; i < 12; i++) begin
            if (last_acc) begin
                h_r0 = 5'(2 * i + 1);
                h_r1 = 5'(2 * i + 2);
                h_d0 = 32'(i) << 8;
                h_d1 = (32'(i) << 8) | 32'h1;
            end
            step(1'b1, h_r0, h_d0, 1'b1, h_r1, h_d1, h_r1);
        end
        idle(4, 5'd0);

        // Random traffic, light then heavy.
        for (int i = 0; i < 150; i++) rand_cycle(1'b0);
        for (int i = 0; i < 150; i++) rand_cycle(1'b1);

        // Refill to three entries, then reset between edges while draining.
        idle(4, 5'd0);
        last_acc = 1'b1;
        step(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 5'd0);
        step(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23, 5'd22);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd22);
        check("pre_rst_pend_count", 37'(pend_count), 37'd3);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_pend_count", 37'(pend_count), 37'd0);
        check("mid_rst_write_enable", 37'(ctrl_writeEnable), 37'd0);
        check("mid_rst_wb_ready", 37'(wb_ready), 37'd1);
        check("mid_rst_probe_hit", 37'(probe_hit), 37'd0);
        check("mid_rst_bus", {ctrl_writeReg, data_writeReg}, 37'd0);
        exp_q.delete();
        pend_q.delete();
        idle(2, 5'd22);
        reset = 1'b1;
        idle(4, 5'd22);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
